uart_rx: RTL and testbench

UART receiver, the downstream counterpart of the team's UART transmitter; it deserialises the transmitter's line output back into bytes. Frame format matches the transmitter: 1 start bit (low), 8 data bits LSB-first, 1 parity bit, then 1 or 2 stop bits (high). Received bytes go into a one-entry holding register with a valid/ready handshake toward the consuming logic (FIFO or bus interface). Parity, framing and overrun errors are reported alongside.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receive-byte handshake bundle between uart_rx and its consumer
interface uart_rx_if;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic       Rx_ready;
    logic       Parity_err;
    logic       Frame_err;

    modport master (
        output Rx_data,
        output Rx_valid,
        output Parity_err,
        output Frame_err,
        input  Rx_ready
    );

    modport slave (
        input  Rx_data,
        input  Rx_valid,
        input  Parity_err,
        input  Frame_err,
        output Rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits, parity, 1/2 stop bits, one-entry holding register
module uart_rx #(
    parameter int BAUD_DIVISOR = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rx_in,
    input  logic        Two_stop,
    input  logic        Odd_parity,
    input  logic        Err_clr,
    output logic        Overrun,
    output logic        Rx_busy,
    uart_rx_if.master   bus
);
    localparam logic [13:0] HALF_CNT = 14'(BAUD_DIVISOR / 2);
    localparam logic [13:0] LAST_CNT = 14'(BAUD_DIVISOR - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s, rx_prev;
    logic [13:0] baud_count;
    logic [2:0]  bit_count;
    logic [7:0]  shift;
    logic        two_stop_l, odd_l;
    logic        par_err_acc, frm_err_acc;
    logic [7:0]  data_q;
    logic        valid_q, perr_q, ferr_q;

    logic fall, half_hit, last_hit;
    logic start_det, data_go, cnt_clr, shift_en, par_en, stop_en, done;
    logic frame_bad;

    assign fall     = rx_prev & ~rx_s;
    assign half_hit = (baud_count == HALF_CNT);
    assign last_hit = (baud_count == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        data_go   = 1'b0;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    start_det = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                if (half_hit) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        data_go = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (last_hit) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bit_count == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (last_hit) begin
                    par_en  = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = STOP1;
                end
            end
            STOP1: begin
                if (last_hit) begin
                    stop_en = 1'b1;
                    cnt_clr = 1'b1;
                    if (two_stop_l) begin
                        state_n = STOP2;
                    end else begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            STOP2: begin
                if (last_hit) begin
                    stop_en = 1'b1;
                    cnt_clr = 1'b1;
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The final stop sample must reach the held flag on the same edge the byte loads.
    assign frame_bad = frm_err_acc | (stop_en & ~rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            baud_count  <= '0;
            bit_count   <= '0;
            shift       <= '0;
            two_stop_l  <= 1'b0;
            odd_l       <= 1'b0;
            par_err_acc <= 1'b0;
            frm_err_acc <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            rx_m    <= Rx_in;
            rx_s    <= rx_m;
            rx_prev <= rx_s;

            if (state == IDLE || cnt_clr) baud_count <= '0;
            else                          baud_count <= baud_count + 14'd1;

            if (start_det) begin
                two_stop_l  <= Two_stop;
                odd_l       <= Odd_parity;
                par_err_acc <= 1'b0;
                frm_err_acc <= 1'b0;
            end
            if (data_go) bit_count <= '0;
            if (shift_en) begin
                shift     <= {rx_s, shift[7:1]};
                bit_count <= bit_count + 3'd1;
            end
            if (par_en) par_err_acc <= (^shift) ^ odd_l ^ rx_s;
            if (stop_en && !rx_s) frm_err_acc <= 1'b1;

            if (done && (!valid_q || bus.Rx_ready)) begin
                data_q  <= shift;
                perr_q  <= par_err_acc;
                ferr_q  <= frame_bad;
                valid_q <= 1'b1;
            end else if (valid_q && bus.Rx_ready) begin
                valid_q <= 1'b0;
            end

            if (done && valid_q && !bus.Rx_ready) Overrun <= 1'b1;
            else if (Err_clr)                     Overrun <= 1'b0;
        end
    end

    assign bus.Rx_data    = data_q;
    assign bus.Rx_valid   = valid_q;
    assign bus.Parity_err = perr_q;
    assign bus.Frame_err  = ferr_q;
    assign Rx_busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at BAUD_DIVISOR=16
module tb_uart_rx;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst, Rx_in, Two_stop, Odd_parity, Err_clr, Overrun, Rx_busy;
    int   compared = 0;
    int   mismatched = 0;
    logic [7:0] got_q[$];

    uart_rx_if bus();

    uart_rx #(.BAUD_DIVISOR(DIV)) dut (
        .clk(clk), .rst(rst), .Rx_in(Rx_in), .Two_stop(Two_stop),
        .Odd_parity(Odd_parity), .Err_clr(Err_clr), .Overrun(Overrun),
        .Rx_busy(Rx_busy), .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && bus.Rx_valid === 1'b1 && bus.Rx_ready === 1'b1)
            got_q.push_back(bus.Rx_data);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        Rx_in = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input logic p);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                              input logic s2, input logic two);
        send_head(d, p);
        drive_bit(s1);
        if (two) drive_bit(s2);
    endtask

    task automatic accept();
        bus.Rx_ready = 1'b1;
        @(negedge clk);
        bus.Rx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; Rx_in = 1'b1; Two_stop = 1'b0; Odd_parity = 1'b0;
        Err_clr = 1'b0; bus.Rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {7'd0, bus.Rx_valid}, 8'd0);
        check("rst_data", bus.Rx_data, 8'h00);
        check("rst_flags", {4'd0, bus.Parity_err, bus.Frame_err, Overrun, Rx_busy}, 8'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // even parity, one stop; Rx_valid must rise just after the stop sample
        send_head(8'hA5, 1'b0);
        Rx_in = 1'b1;
        repeat (11) @(negedge clk);
        check("a5_before_stop", {7'd0, bus.Rx_valid}, 8'd0);
        @(negedge clk);
        check("a5_valid", {7'd0, bus.Rx_valid}, 8'd1);
        check("a5_data", bus.Rx_data, 8'hA5);
        check("a5_errs", {6'd0, bus.Parity_err, bus.Frame_err}, 8'd0);
        repeat (4) @(negedge clk);
        accept();
        check("a5_released", {7'd0, bus.Rx_valid}, 8'd0);

        // odd parity, two stops
        Two_stop = 1'b1; Odd_parity = 1'b1;
        send_head(8'h01, 1'b0);
        drive_bit(1'b1);
        check("odd_no_early", {7'd0, bus.Rx_valid}, 8'd0);
        Rx_in = 1'b1;
        repeat (12) @(negedge clk);
        check("odd_valid", {7'd0, bus.Rx_valid}, 8'd1);
        check("odd_data", bus.Rx_data, 8'h01);
        check("odd_perr0", {7'd0, bus.Parity_err}, 8'd0);
        repeat (4) @(negedge clk);
        accept();
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("odd2_valid", {7'd0, bus.Rx_valid}, 8'd1);
        check("odd2_perr1", {7'd0, bus.Parity_err}, 8'd1);
        check("odd2_ferr0", {7'd0, bus.Frame_err}, 8'd0);
        accept();

        // false start shorter than half a bit
        Two_stop = 1'b0; Odd_parity = 1'b0;
        Rx_in = 1'b0;
        repeat (3) @(negedge clk);
        check("fs_busy", {7'd0, Rx_busy}, 8'd1);
        repeat (2) @(negedge clk);
        Rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("fs_idle", {7'd0, Rx_busy}, 8'd0);
        check("fs_novalid", {7'd0, bus.Rx_valid}, 8'd0);

        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("fe_data", bus.Rx_data, 8'h3C);
        check("fe_ferr", {7'd0, bus.Frame_err}, 8'd1);
        check("fe_perr", {7'd0, bus.Parity_err}, 8'd0);
        accept();
        repeat (300) @(negedge clk);
        check("brk_novalid", {7'd0, bus.Rx_valid}, 8'd0);
        check("brk_idle", {7'd0, Rx_busy}, 8'd0);
        Rx_in = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("rec_data", bus.Rx_data, 8'h5A);
        check("rec_ferr", {7'd0, bus.Frame_err}, 8'd0);
        accept();

        // overrun with consumer stalled
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("ov_data", bus.Rx_data, 8'h11);
        check("ov_flag", {7'd0, Overrun}, 8'd1);
        accept();
        check("ov_drained", {7'd0, bus.Rx_valid}, 8'd0);
        check("ov_sticky", {7'd0, Overrun}, 8'd1);
        Err_clr = 1'b1;
        @(negedge clk);
        Err_clr = 1'b0;
        check("ov_cleared", {7'd0, Overrun}, 8'd0);

        // back-to-back with consumer always ready
        got_q.delete();
        bus.Rx_ready = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_count", 8'(got_q.size()), 8'd2);
        if (got_q.size() == 2) begin
            check("b2b_first", got_q[0], 8'h55);
            check("b2b_second", got_q[1], 8'hAA);
        end
        check("b2b_noov", {7'd0, Overrun}, 8'd0);
        check("b2b_held", bus.Rx_data, 8'hAA);

        // reset in the middle of a frame
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        check("mid_busy", {7'd0, Rx_busy}, 8'd1);
        rst = 1'b1;
        Rx_in = 1'b1;
        @(negedge clk);
        check("mr_data", bus.Rx_data, 8'h00);
        check("mr_flags", {3'd0, bus.Rx_valid, bus.Parity_err, bus.Frame_err, Overrun, Rx_busy}, 8'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("mr_nodeliver", 8'(got_q.size()), 8'd2);
        check("mr_novalid", {7'd0, bus.Rx_valid}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
